sap_ram: RTL
============

// Module: sap_ram
// PURPOSE
//  - Main memory for the SAP-1 datapath. It sits on the far side of the memory address register:
//    it takes the registered address from that register and answers bus reads and writes at that address.
//  - Program mode: a front-panel/loader valid/ready port fills memory while the CPU is held.
//  - Optional clear sweep after reset, so every run starts from a known memory image.
// PARAMETERS
//  ADDR_W          4   address width; depth = 2**ADDR_W words
//  DATA_W          8   word width
//  CLEAR_ON_RESET  1   1: zero every word after reset release; 0: skip straight to S_RUN
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       reset, asynchronous, active-high
//  address_in  in   ADDR_W  address from memory address register (held stable by it)
//  oe          in   1       run-mode read request (drive bus next cycle)
//  we          in   1       run-mode write request from bus
//  bus_in      in   DATA_W  write data from bus
//  data_out    out  DATA_W  registered read data
//  bus_drive   out  1       data_out valid / bus-enable, 1 cycle after oe
//  prog_mode   in   1       1 = program mode (CPU halted)
//  prog_addr   in   ADDR_W  loader address
//  prog_data   in   DATA_W  loader data
//  prog_valid  in   1       loader word offered
//  prog_ready  out  1       memory accepts loader word this cycle
//  busy        out  1       clear sweep in progress
// BEHAVIOUR
//  - Reset (async): data_out=0, bus_drive=0, prog_ready=0, sweep counter=0.
//    State goes to S_CLEAR if CLEAR_ON_RESET=1, else S_RUN. busy=CLEAR_ON_RESET.
//  - Reset asserted mid-sweep or mid-load restarts from that reset state.
//    Memory words already written stay as-is until the sweep rewrites them.
//  - S_CLEAR: one word per clk: mem[cnt]<=0, cnt++. busy=1. oe, we and prog_* are ignored.
//    After writing word 2**ADDR_W-1: cnt wraps to 0, busy=0, next state S_RUN.
//    Sweep takes exactly 2**ADDR_W cycles.
//  - S_RUN (prog_mode=0):
//    - oe=1 at edge N: data_out<=mem[address_in] and bus_drive=1, both after edge N.
//    - oe=0: bus_drive<=0 and data_out holds its last value.
//    - we=1 and oe=0: mem[address_in]<=bus_in at the edge.
//    - we=1 and oe=1: bus contention. The write is dropped and the read is performed.
//    - prog_ready=0.
//  - S_PROG (prog_mode=1):
//    - prog_ready=1 combinationally while in S_PROG.
//    - prog_valid & prog_ready at edge: mem[prog_addr]<=prog_data. One word per cycle, no backpressure.
//    - oe and we are ignored. bus_drive<=0.
//  - Transitions:
//    - S_RUN -> S_PROG when prog_mode=1 is sampled. S_PROG -> S_RUN when prog_mode=0 is sampled.
//    - prog_ready drops in the cycle after prog_mode falls.
//    - A word offered in the same cycle that prog_mode is sampled low is not written.
//    - prog_mode during S_CLEAR is deferred: after the sweep, go straight to S_PROG if prog_mode=1.
//  - Read during write at the same address: read returns the old word (read-first).
//  - Addresses are ADDR_W bits and index the full depth; no out-of-range case.
// STRUCTURE
//  - sap_pkg: typedef enum {S_CLEAR,S_RUN,S_PROG} ram_state_t; SAP_ADDR_W=4, SAP_DATA_W=8.
//  - Sub-module sap_ram_array: 1 write port, 1 synchronous read port, read-first.
//    The FSM, write-port mux (sweep / loader / bus) and output register sit in sap_ram.
// TESTING
//  1. rst pulse, CLEAR_ON_RESET=1 -> busy=1 for exactly 16 clks; then oe at each address returns 8'h00.
//  2. prog_mode=1; load 0:8'h1E, 1:8'h2F, 15:8'hE0 back-to-back with prog_valid=1 -> prog_ready=1 each cycle;
//     run-mode reads of addresses 0, 1 and 15 return the same values, bus_drive one cycle after oe.
//  3. Run mode, address_in=4'h3: we=1 with bus_in=8'hA5, next cycle oe=1 -> data_out=8'hA5.
//     Then oe=1 and we=1 with bus_in=8'h00 -> read returns 8'hA5 and mem[3] stays 8'hA5.
//  4. Read-first: oe=1 then we=1 with 8'h77 at address 4'h5 holding 8'h11, same edge -> data_out=8'h11;
//     next read returns 8'h11 (write dropped by contention rule). Repeat with oe=0 on the write cycle -> 8'h77.
//  5. rst asserted at sweep cycle 7 -> outputs zero immediately; after release the sweep restarts at 0 and takes 16 clks.
//  6. prog_mode held 1 through a sweep -> no prog_ready during busy; S_PROG entered the cycle after busy falls.
//     prog_mode falling with prog_valid=1 -> that word is not written.

Source files
------------

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared types and default widths for the SAP-1 main memory
package sap_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_PROG  = 2'd2
  } ram_state_t;

endpackage

// File: rtl/sap_ram_array.sv
// rtl/sap_ram_array.sv - single write port, single synchronous read-first read port storage
module sap_ram_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Storage write; contents are deliberately not reset so a reset leaves words as-is
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data sampled from the array before this edge's write lands: read-first
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // Read register; holds its last value when no read is requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sap_ram.sv
// rtl/sap_ram.sv - SAP-1 main memory with bus port, loader port and post-reset clear sweep
module sap_ram
  import sap_pkg::*;
#(
  parameter int ADDR_W         = SAP_ADDR_W,
  parameter int DATA_W         = SAP_DATA_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              oe,
  input  logic              we,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] data_out,
  output logic              bus_drive,
  input  logic              prog_mode,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic              busy
);

  localparam ram_state_t       RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              bus_drive_q, bus_drive_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;

  // Next state plus write-port mux: sweep, loader or bus, chosen by the current mode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_drive_d = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = address_in;
    wr_data     = bus_in;
    rd_en       = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          // A loader request seen during the sweep takes effect as soon as it ends
          state_d = prog_mode ? S_PROG : S_RUN;
        end
      end
      S_RUN: begin
        rd_en       = oe;
        bus_drive_d = oe;
        // Simultaneous oe and we is contention: the read wins, the write is dropped
        wr_en       = we & ~oe;
        if (prog_mode) begin
          state_d = S_PROG;
        end
      end
      S_PROG: begin
        wr_addr = prog_addr;
        wr_data = prog_data;
        if (prog_mode) begin
          wr_en = prog_valid;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Mode, sweep counter and bus-enable registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      bus_drive_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_drive_q <= bus_drive_d;
    end
  end

  sap_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (address_in),
    .rd_data (data_out)
  );

  assign bus_drive  = bus_drive_q;
  assign prog_ready = (state_q == S_PROG);
  assign busy       = (state_q == S_CLEAR);

endmodule
